// File: rtl/inst_fetch_resp.sv
// -----------------------------------------------------------------------------
// inst_fetch_resp
//
// Memory-side responder for instruction fetches coming out of the IF stage.
// Turns each fetch strobe into one SRAM-like req/addr_ok/data_ok transaction.
// The returned word goes to the IF/ID register, and the pipeline is stalled
// while the transaction is outstanding. A fetch that IF has already flagged
// with an exception never reaches the bus. Instead it completes at once with
// NOP_WORD and the incoming exception code.
//
// Ports
//   cpu_clk_50M     in   clock, all state on the rising edge
//   cpu_rst         in   asynchronous, active-high reset
//   if_ce_i         in   fetch request valid this cycle
//   if_inst_addr_i  in   physical fetch address
//   if_exc_code_i   in   exception code attached to the fetch by IF
//   stall_i         in   IF/ID cannot take a result this cycle
//   flush_i         in   kill the current fetch (redirect / exception)
//   inst_o          out  returned instruction word
//   inst_valid_o    out  inst_o / exc_code_o valid; consumed when !stall_i
//   exc_code_o      out  exception attached to inst_o
//   stall_req_o     out  pipeline stall request while a fetch is in flight
//   mem_req_o       out  bus request (registered)
//   mem_addr_o      out  bus address (registered, stable until addr_ok)
//   mem_addr_ok_i   in   bus accepted the address this cycle
//   mem_data_ok_i   in   bus returns mem_rdata_i this cycle
//   mem_rdata_i     in   bus read data
// -----------------------------------------------------------------------------
module inst_fetch_resp #(
    parameter int               EXC_W    = 5,
    parameter int               TIMEOUT  = 255,
    parameter logic [EXC_W-1:0] EC_NONE  = '0,
    parameter logic [EXC_W-1:0] EC_IBE   = EXC_W'(6),
    parameter logic [31:0]      NOP_WORD = 32'h0
) (
    input  logic             cpu_clk_50M,
    input  logic             cpu_rst,
    input  logic             if_ce_i,
    input  logic [31:0]      if_inst_addr_i,
    input  logic [EXC_W-1:0] if_exc_code_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [31:0]      inst_o,
    output logic             inst_valid_o,
    output logic [EXC_W-1:0] exc_code_o,
    output logic             stall_req_o,
    output logic             mem_req_o,
    output logic [31:0]      mem_addr_o,
    input  logic             mem_addr_ok_i,
    input  logic             mem_data_ok_i,
    input  logic [31:0]      mem_rdata_i
);

    localparam int CTR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t             r_state;
    logic [CTR_W-1:0]   r_ctr;
    logic               r_drop_seen;   // late data_ok already absorbed in DROP
    logic [31:0]        r_inst;
    logic [EXC_W-1:0]   r_exc;
    logic               r_valid;
    logic               r_req;
    logic [31:0]        r_addr;

    logic w_accept;
    logic w_fault;
    logic w_drop_done;
    logic w_keep_result;

    // A new fetch is taken in IDLE, or from HOLD in the same cycle the held
    // result is consumed (back-to-back). A flush always wins.
    assign w_accept = if_ce_i && !flush_i &&
                      ((r_state == S_IDLE) || ((r_state == S_HOLD) && !stall_i));
    assign w_fault  = (if_exc_code_i != EC_NONE);

    // DROP may only end once the outstanding data_ok has been seen. A timeout
    // result that is still waiting for the consumer keeps DROP alive too.
    assign w_drop_done   = r_drop_seen || mem_data_ok_i;
    assign w_keep_result = r_valid && stall_i && !flush_i;

    assign stall_req_o = (r_state == S_ADDR) || (r_state == S_WAIT) ||
                         (r_state == S_DROP) ||
                         ((r_state == S_IDLE) && w_accept);

    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;
    assign exc_code_o   = r_exc;
    assign mem_req_o    = r_req;
    assign mem_addr_o   = r_addr;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state     <= S_IDLE;
            r_ctr       <= '0;
            r_drop_seen <= 1'b0;
            r_inst      <= '0;
            r_exc       <= EC_NONE;
            r_valid     <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= '0;
        end else if (w_accept) begin
            if (w_fault) begin
                // Faulted fetch completes locally, the bus is never touched.
                r_state <= S_HOLD;
                r_inst  <= NOP_WORD;
                r_exc   <= if_exc_code_i;
                r_valid <= 1'b1;
                r_req   <= 1'b0;
            end else begin
                r_state <= S_ADDR;
                r_addr  <= if_inst_addr_i;
                r_req   <= 1'b1;
                r_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                S_IDLE: ;

                S_ADDR: begin
                    if (flush_i) begin
                        r_req <= 1'b0;
                        // Once the address is accepted, the data beat is owed to us.
                        if (mem_addr_ok_i) begin
                            r_state     <= S_DROP;
                            r_drop_seen <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (mem_addr_ok_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                        r_ctr   <= '0;
                    end
                end

                S_WAIT: begin
                    r_ctr <= r_ctr + 1'b1;
                    if (flush_i) begin
                        // Data arriving with the flush closes the transaction.
                        if (mem_data_ok_i) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state     <= S_DROP;
                            r_drop_seen <= 1'b0;
                        end
                    end else if (mem_data_ok_i) begin
                        r_state <= S_HOLD;
                        r_inst  <= mem_rdata_i;
                        r_exc   <= EC_NONE;
                        r_valid <= 1'b1;
                    end else if (r_ctr == CTR_W'(TIMEOUT - 1)) begin
                        // Bus error: deliver it now, still drain the late beat.
                        r_state     <= S_DROP;
                        r_drop_seen <= 1'b0;
                        r_inst      <= NOP_WORD;
                        r_exc       <= EC_IBE;
                        r_valid     <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (flush_i || !stall_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_DROP: begin
                    if (r_valid && (flush_i || !stall_i))
                        r_valid <= 1'b0;
                    if (mem_data_ok_i)
                        r_drop_seen <= 1'b1;
                    if (w_drop_done && !w_keep_result)
                        r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The bus must not return data before it has accepted the address.
    a_no_early_data : assert property (@(posedge cpu_clk_50M) disable iff (cpu_rst)
        !((r_state == S_ADDR) && mem_data_ok_i));

endmodule

// File: tb/tb_inst_fetch_resp.sv
module tb_inst_fetch_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic [31:0] addr = '0;
    logic [4:0]  exc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [4:0]  exc_code_o;
    logic        stall_req_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic [31:0] rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;
    int n_req  = 0;
    int n_vld  = 0;
    logic prev_req = 1'b0;
    logic prev_vld = 1'b0;
    int   n0, v0;

    always #5 clk = ~clk;

    inst_fetch_resp #(
        .EXC_W(5), .TIMEOUT(8), .EC_NONE(5'd0), .EC_IBE(5'd6), .NOP_WORD(32'h0)
    ) dut (
        .cpu_clk_50M   (clk),
        .cpu_rst       (rst),
        .if_ce_i       (ce),
        .if_inst_addr_i(addr),
        .if_exc_code_i (exc),
        .stall_i       (stall),
        .flush_i       (flush),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .exc_code_o    (exc_code_o),
        .stall_req_o   (stall_req_o),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_addr_ok_i (addr_ok),
        .mem_data_ok_i (data_ok),
        .mem_rdata_i   (rdata)
    );

    // Count bus requests and valid pulses (rising edges), sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_req_o && !prev_req) n_req++;
        if (inst_valid_o && !prev_vld) n_vld++;
        prev_req <= mem_req_o;
        prev_vld <= inst_valid_o;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        chk("rst_inst",  inst_o, 32'h0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_exc",   exc_code_o, 0);
        chk("rst_stall", stall_req_o, 0);
        chk("rst_req",   mem_req_o, 0);
        chk("rst_addr",  mem_addr_o, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single fetch, addr_ok same cycle as req, data_ok one later
        n0 = n_req;
        ce = 1; addr = 32'h0040_0000; exc = 0;
        #1 chk("t1_stall_accept", stall_req_o, 1);
        tick();
        chk("t1_req", mem_req_o, 1);
        chk("t1_addr", mem_addr_o, 32'h0040_0000);
        chk("t1_no_valid_yet", inst_valid_o, 0);
        ce = 0; addr_ok = 1;
        tick();
        chk("t1_req_cleared", mem_req_o, 0);
        chk("t1_wait_no_valid", inst_valid_o, 0);
        addr_ok = 0; data_ok = 1; rdata = 32'h2408_0001;
        tick();
        chk("t1_valid", inst_valid_o, 1);
        chk("t1_inst", inst_o, 32'h2408_0001);
        chk("t1_exc", exc_code_o, 0);
        data_ok = 0;
        #1 chk("t1_hold_nostall", stall_req_o, 0);
        tick();
        chk("t1_valid_consumed", inst_valid_o, 0);
        chk("t1_one_req", n_req - n0, 1);

        // 2: faulted fetch (AdEL) never reaches the bus
        n0 = n_req;
        ce = 1; addr = 32'h0040_0002; exc = 5'd4;
        #1 chk("t2_stall_accept", stall_req_o, 1);
        tick();
        chk("t2_valid", inst_valid_o, 1);
        chk("t2_inst", inst_o, 32'h0);
        chk("t2_exc", exc_code_o, 4);
        chk("t2_no_req", mem_req_o, 0);
        ce = 0; exc = 0;
        tick();
        chk("t2_valid_consumed", inst_valid_o, 0);
        chk("t2_zero_reqs", n_req - n0, 0);

        // 3: wait states, addr_ok after 3 cycles, data_ok after 5 more
        v0 = n_vld;
        ce = 1; addr = 32'h0040_0010;
        tick();
        ce = 0; addr = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_held", mem_req_o, 1);
            chk("t3_addr_stable", mem_addr_o, 32'h0040_0010);
            #1 chk("t3_stall_addr", stall_req_o, 1);
            tick();
        end
        chk("t3_addr_stable_ok", mem_addr_o, 32'h0040_0010);
        addr_ok = 1;
        tick();
        addr_ok = 0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_wait", stall_req_o, 1);
            chk("t3_no_valid", inst_valid_o, 0);
            tick();
        end
        data_ok = 1; rdata = 32'h8C09_0004;
        tick();
        data_ok = 0;
        chk("t3_valid", inst_valid_o, 1);
        chk("t3_inst", inst_o, 32'h8C09_0004);
        tick();
        chk("t3_valid_consumed", inst_valid_o, 0);
        chk("t3_one_pulse", n_vld - v0, 1);

        // 4: flush in WAIT_DATA, late data_ok discarded, next fetch waits for it
        v0 = n_vld;
        ce = 1; addr = 32'h0040_0020;
        tick();
        ce = 0; addr_ok = 1;
        tick();
        addr_ok = 0; flush = 1;
        tick();
        flush = 0;
        chk("t4_drop_no_valid", inst_valid_o, 0);
        ce = 1; addr = 32'h0040_0024;
        #1 chk("t4_drop_stall", stall_req_o, 1);
        tick();
        chk("t4_no_new_req", mem_req_o, 0);
        data_ok = 1; rdata = 32'hBAD0_BAD0;
        tick();
        data_ok = 0;
        chk("t4_no_req_after_data", mem_req_o, 0);
        chk("t4_discarded", inst_valid_o, 0);
        #1 chk("t4_idle_accept", stall_req_o, 1);
        tick();
        ce = 0;
        chk("t4_next_req", mem_req_o, 1);
        chk("t4_next_addr", mem_addr_o, 32'h0040_0024);
        addr_ok = 1;
        tick();
        addr_ok = 0; data_ok = 1; rdata = 32'h0000_1234;
        tick();
        data_ok = 0;
        chk("t4_next_inst", inst_o, 32'h0000_1234);
        tick();
        chk("t4_one_pulse", n_vld - v0, 1);

        // 5: timeout after 8 cycles in WAIT_DATA, late data_ok absorbed
        v0 = n_vld;
        ce = 1; addr = 32'h0040_0030;
        tick();
        ce = 0; addr_ok = 1;
        tick();
        addr_ok = 0;
        for (int i = 0; i < 8; i++) begin
            chk("t5_no_valid", inst_valid_o, 0);
            tick();
        end
        chk("t5_valid", inst_valid_o, 1);
        chk("t5_exc", exc_code_o, 6);
        chk("t5_inst", inst_o, 32'h0);
        stall = 1;
        #1 chk("t5_drop_stall", stall_req_o, 1);
        tick();
        chk("t5_held", inst_valid_o, 1);
        stall = 0;
        tick();
        chk("t5_consumed", inst_valid_o, 0);
        chk("t5_still_drop", stall_req_o, 1);
        data_ok = 1;
        tick();
        data_ok = 0;
        chk("t5_back_idle", stall_req_o, 0);
        chk("t5_late_absorbed", inst_valid_o, 0);
        chk("t5_one_pulse", n_vld - v0, 1);

        // 6: back-to-back with stall held 2 cycles, then async reset mid-WAIT
        ce = 1; addr = 32'h0040_0040;
        tick();
        ce = 0; addr_ok = 1;
        tick();
        addr_ok = 0; data_ok = 1; rdata = 32'h1111_1111; stall = 1;
        tick();
        data_ok = 0;
        ce = 1; addr = 32'h0040_0044;
        for (int i = 0; i < 2; i++) begin
            chk("t6_valid_held", inst_valid_o, 1);
            chk("t6_inst_held", inst_o, 32'h1111_1111);
            chk("t6_no_req", mem_req_o, 0);
            #1 chk("t6_hold_nostall", stall_req_o, 0);
            tick();
        end
        stall = 0;
        tick();
        ce = 0;
        chk("t6_second_req", mem_req_o, 1);
        chk("t6_second_addr", mem_addr_o, 32'h0040_0044);
        chk("t6_valid_gone", inst_valid_o, 0);
        addr_ok = 1;
        tick();
        addr_ok = 0;
        chk("t6_in_wait", stall_req_o, 1);
        rst = 1;
        #1;
        chk("t6_rst_inst", inst_o, 32'h0);
        chk("t6_rst_valid", inst_valid_o, 0);
        chk("t6_rst_exc", exc_code_o, 0);
        chk("t6_rst_stall", stall_req_o, 0);
        chk("t6_rst_req", mem_req_o, 0);
        chk("t6_rst_addr", mem_addr_o, 32'h0);
        tick();
        rst = 0;
        tick();
        chk("t6_post_rst_idle", stall_req_o, 0);
        chk("t6_post_rst_req", mem_req_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
